// File: rtl/pwm_duty_ctrl.sv
// Push-button duty control for the LED PWM stage: synchronise, debounce, step
// the 10-bit duty word with saturation, and auto-repeat while a key is held.
module pwm_duty_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned STEP            = 1,
  parameter logic [9:0]  DUTY_RESET      = 10'h3F8,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key,
  output logic [9:0] duty,
  output logic       duty_valid,
  output logic       at_max,
  output logic       at_min,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] DELAY_LD  = REPEAT_DELAY;
  localparam logic [31:0] PERIOD_LD = REPEAT_PERIOD;
  localparam logic [10:0] STEP_W    = 11'(STEP);

  logic [1:0]  sync1, sync2, fill;
  logic [1:0]  deb, deb_q, armed;
  logic [19:0] dcnt [2];

  state_t      state, state_next;
  logic        dir, dir_next;
  logic [31:0] rcnt, rcnt_next;
  logic        do_step, step_down;
  logic        sel_up, sel_dn, req_up, req_dn, release_key;
  logic [10:0] sum_up;
  logic [9:0]  up_val, dn_val, new_duty;

  // fill marks when sync2 holds a real sample rather than its reset value;
  // a key is armed only once it has been seen low after reset, so a key
  // held through reset never produces a step until it is pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      fill    <= '0;
      deb     <= '0;
      deb_q   <= '0;
      armed   <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          deb[i]  <= ~deb[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 20'd1;
        end
        if (fill[1] && !sync2[i]) begin
          armed[i] <= 1'b1;
        end
      end
    end
  end

  // A request is the debounced level entering "exactly this key pressed",
  // so dropping from both-pressed to one key also counts as a press.
  always_comb begin
    sel_up      = (deb == 2'b01);
    sel_dn      = (deb == 2'b10);
    req_up      = sel_up && (deb_q != 2'b01) && armed[0];
    req_dn      = sel_dn && (deb_q != 2'b10) && armed[1];
    release_key = (dir ? !deb[1] : !deb[0]) || (deb == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir   <= 1'b0;
      rcnt  <= '0;
    end else begin
      state <= state_next;
      dir   <= dir_next;
      rcnt  <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    if (req_up || req_dn) begin
      state_next = HOLD;
    end else if (state != IDLE && release_key) begin
      state_next = IDLE;
    end else if (state == HOLD && rcnt == 32'd0 && DELAY_LD != 32'd0) begin
      state_next = REPEAT;
    end
  end

  always_comb begin
    do_step   = 1'b0;
    step_down = dir;
    dir_next  = dir;
    rcnt_next = rcnt;
    if (req_up || req_dn) begin
      do_step   = 1'b1;
      step_down = req_dn;
      dir_next  = req_dn;
      rcnt_next = DELAY_LD;
    end else if (state != IDLE && release_key) begin
      rcnt_next = '0;
    end else if (state == HOLD) begin
      if (rcnt != 32'd0) begin
        rcnt_next = rcnt - 32'd1;
      end else if (DELAY_LD != 32'd0) begin
        do_step   = 1'b1;
        rcnt_next = PERIOD_LD;
      end
    end else if (state == REPEAT) begin
      if (rcnt != 32'd0) begin
        rcnt_next = rcnt - 32'd1;
      end else begin
        do_step   = 1'b1;
        rcnt_next = PERIOD_LD;
      end
    end
  end

  always_comb begin
    sum_up   = {1'b0, duty} + STEP_W;
    up_val   = (sum_up > 11'd1023) ? 10'h3FF : sum_up[9:0];
    dn_val   = (STEP_W > {1'b0, duty}) ? 10'd0 : (duty - STEP_W[9:0]);
    new_duty = step_down ? dn_val : up_val;
  end

  // duty is a held level; duty_valid is a one-cycle strobe raised only on
  // the cycle duty takes a different value, with no back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty       <= DUTY_RESET;
      duty_valid <= 1'b0;
      at_max     <= (DUTY_RESET == 10'h3FF);
      at_min     <= (DUTY_RESET == 10'h000);
    end else begin
      duty_valid <= 1'b0;
      if (do_step && new_duty != duty) begin
        duty       <= new_duty;
        duty_valid <= 1'b1;
        at_max     <= (new_duty == 10'h3FF);
        at_min     <= (new_duty == 10'h000);
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: timed duty updates are queued as {cycle, duty}
// when a key is driven and matched against every duty_valid strobe.
module tb_pwm_duty_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 16;
  localparam int RP  = 8;
  localparam int LAT = 1 + 2 + DEB;

  logic       clk = 1'b0;
  logic       rst, rst_b;
  logic [1:0] key, key_b;
  logic [9:0] duty, duty_b;
  logic       duty_valid, duty_valid_b;
  logic       at_max, at_max_b, at_min, at_min_b;
  logic [1:0] fsm_state, fsm_state_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  pwm_duty_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .STEP(1), .DUTY_RESET(10'h3F8),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (
    .clk(clk), .rst(rst), .key(key), .duty(duty), .duty_valid(duty_valid),
    .at_max(at_max), .at_min(at_min), .fsm_state(fsm_state)
  );

  pwm_duty_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .STEP(4), .DUTY_RESET(10'd1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (
    .clk(clk), .rst(rst_b), .key(key_b), .duty(duty_b), .duty_valid(duty_valid_b),
    .at_max(at_max_b), .at_min(at_min_b), .fsm_state(fsm_state_b)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int c, input logic [9:0] d);
    logic [31:0] cc;
    cc = c;
    return {cc[21:0], d};
  endfunction

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst = 1'b1;
    step_cycles(3);
    rst = 1'b0;
    step_cycles(4);
  endtask

  // scoreboard: every strobe must match the oldest queued {cycle, duty}
  always @(negedge clk) begin
    logic [31:0] now_c;
    now_c = cyc;
    if (duty_valid === 1'b1) begin
      pulses_a++;
      check_eq("pulse_a_pending", 32'(exp_q_a.size() > 0), 32'd1);
      if (exp_q_a.size() > 0) check_eq("pulse_a", {now_c[21:0], duty}, exp_q_a.pop_front());
    end
    if (duty_valid_b === 1'b1) begin
      pulses_b++;
      check_eq("pulse_b_pending", 32'(exp_q_b.size() > 0), 32'd1);
      if (exp_q_b.size() > 0) check_eq("pulse_b", {now_c[21:0], duty_b}, exp_q_b.pop_front());
    end
  end

  initial begin
    int t0, t1, p0;
    rst = 1'b1; rst_b = 1'b1; key = 2'b00; key_b = 2'b00;
    step_cycles(3);
    rst = 1'b0; rst_b = 1'b0;
    check_eq("rst_duty", 32'(duty), 32'd1016);
    check_eq("rst_valid", 32'(duty_valid), 32'd0);
    check_eq("rst_at_max", 32'(at_max), 32'd0);
    check_eq("rst_at_min", 32'(at_min), 32'd0);
    check_eq("rst_state", 32'(fsm_state), 32'd0);
    check_eq("rst_b_duty", 32'(duty_b), 32'd1);
    check_eq("rst_b_at_min", 32'(at_min_b), 32'd0);
    step_cycles(4);

    // single press up, then a short glitch that must be ignored
    key = 2'b01; t0 = cyc;
    exp_q_a.push_back(ent(t0 + LAT, 10'd1017));
    step_cycles(6);
    key = 2'b00;
    step_cycles(15);
    check_eq("press_duty", 32'(duty), 32'd1017);
    check_eq("press_state", 32'(fsm_state), 32'd0);
    p0 = pulses_a;
    key = 2'b01;
    step_cycles(3);
    key = 2'b00;
    step_cycles(12);
    check_eq("glitch_pulses", 32'(pulses_a - p0), 32'd0);
    check_eq("glitch_duty", 32'(duty), 32'd1017);

    // hold for auto-repeat up to saturation
    reset_a();
    key = 2'b01; t0 = cyc;
    exp_q_a.push_back(ent(t0 + LAT, 10'd1017));
    for (int k = 0; k < 6; k++)
      exp_q_a.push_back(ent(t0 + LAT + RD + 1 + k * (RP + 1), 10'(1018 + k)));
    step_cycles(100);
    check_eq("hold_duty", 32'(duty), 32'd1023);
    check_eq("hold_at_max", 32'(at_max), 32'd1);
    check_eq("hold_at_min", 32'(at_min), 32'd0);
    check_eq("hold_state", 32'(fsm_state), 32'd2);
    key = 2'b00;
    step_cycles(10);
    check_eq("hold_release_state", 32'(fsm_state), 32'd0);

    // both keys freeze the repeat; dropping to down-only steps once
    reset_a();
    key = 2'b01; t0 = cyc;
    exp_q_a.push_back(ent(t0 + LAT, 10'd1017));
    exp_q_a.push_back(ent(t0 + LAT + RD + 1, 10'd1018));
    step_cycles(25);
    key = 2'b11;
    step_cycles(20);
    check_eq("both_duty", 32'(duty), 32'd1018);
    check_eq("both_state", 32'(fsm_state), 32'd0);
    key = 2'b10; t1 = cyc;
    exp_q_a.push_back(ent(t1 + LAT, 10'd1017));
    step_cycles(8);
    key = 2'b00;
    step_cycles(12);
    check_eq("both_down_duty", 32'(duty), 32'd1017);

    // reset while repeating with the key held
    reset_a();
    key = 2'b01; t0 = cyc;
    exp_q_a.push_back(ent(t0 + LAT, 10'd1017));
    exp_q_a.push_back(ent(t0 + LAT + RD + 1, 10'd1018));
    step_cycles(30);
    check_eq("midrst_pre_state", 32'(fsm_state), 32'd2);
    rst = 1'b1;
    step_cycles(2);
    rst = 1'b0;
    step_cycles(1);
    check_eq("midrst_duty", 32'(duty), 32'd1016);
    check_eq("midrst_state", 32'(fsm_state), 32'd0);
    step_cycles(30);
    check_eq("midrst_held_duty", 32'(duty), 32'd1016);
    key = 2'b00;
    step_cycles(12);
    key = 2'b01; t1 = cyc;
    exp_q_a.push_back(ent(t1 + LAT, 10'd1017));
    step_cycles(6);
    key = 2'b00;
    step_cycles(12);
    check_eq("midrst_repress_duty", 32'(duty), 32'd1017);

    // instance b: STEP=4 from 1, saturating at zero
    key_b = 2'b10; t0 = cyc;
    exp_q_b.push_back(ent(t0 + LAT, 10'd0));
    step_cycles(6);
    key_b = 2'b00;
    step_cycles(12);
    check_eq("zero_duty", 32'(duty_b), 32'd0);
    check_eq("zero_at_min", 32'(at_min_b), 32'd1);
    p0 = pulses_b;
    key_b = 2'b10;
    step_cycles(6);
    key_b = 2'b00;
    step_cycles(12);
    check_eq("zero_again_pulses", 32'(pulses_b - p0), 32'd0);
    check_eq("zero_again_duty", 32'(duty_b), 32'd0);
    key_b = 2'b01; t0 = cyc;
    exp_q_b.push_back(ent(t0 + LAT, 10'd4));
    step_cycles(6);
    key_b = 2'b00;
    step_cycles(12);
    check_eq("b_up_duty", 32'(duty_b), 32'd4);
    check_eq("b_up_at_min", 32'(at_min_b), 32'd0);

    // final report
    check_eq("exp_q_a_drained", 32'(exp_q_a.size()), 32'd0);
    check_eq("exp_q_b_drained", 32'(exp_q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
